// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: register rename map with a free bitmap, per-physical ready
// bits and a ring of NUM_CKPT {map, free} snapshots for branch recovery.
// Optional feature macro: RENAME_WB_BYPASS_EN (same-cycle writeback bypass
// onto rs_rdy/rt_rdy).
//
// Handshake: a rename request is taken on any cycle where rn_valid and
// rn_ready are both high; rn_ready never depends on rn_valid, and the lookup
// and allocation outputs are valid in that same cycle.
module rename_map_ckpt #(
  parameter int LOG_REGS = 32,
  parameter int PHY_REGS = 64,
  parameter int TAG_W    = 4,
  parameter int NUM_CKPT = 4,
  localparam int LW = $clog2(LOG_REGS),
  localparam int PW = $clog2(PHY_REGS),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rn_valid,
  input  logic             rn_uses_rw,
  input  logic             rn_branch,
  input  logic [LW-1:0]    rn_rs,
  input  logic [LW-1:0]    rn_rt,
  input  logic [LW-1:0]    rn_rw,
  input  logic [TAG_W-1:0] rn_rob_tag,
  output logic             rn_ready,
  output logic [PW-1:0]    rs_phy,
  output logic [PW-1:0]    rt_phy,
  output logic             rs_rdy,
  output logic             rt_rdy,
  output logic [TAG_W-1:0] rs_tag,
  output logic [TAG_W-1:0] rt_tag,
  output logic [PW-1:0]    rw_phy,
  output logic [PW-1:0]    rw_old_phy,
  output logic [CW-1:0]    ckpt_id,
  input  logic             wb_valid,
  input  logic [PW-1:0]    wb_phy,
  input  logic             commit_valid,
  input  logic [PW-1:0]    commit_old_phy,
  input  logic             br_valid,
  input  logic             br_mispredict,
  output logic [PW:0]      free_count,
  output logic             ckpt_full
);

  localparam logic [PHY_REGS-1:0] ONE_BIT  = {{(PHY_REGS-1){1'b0}}, 1'b1};
  localparam logic [PHY_REGS-1:0] FREE_RST = {PHY_REGS{1'b1}} << LOG_REGS;

  logic [PW-1:0]       map_q     [LOG_REGS];
  logic [TAG_W-1:0]    tag_q     [PHY_REGS];
  logic [PHY_REGS-1:0] ready_q;
  logic [PHY_REGS-1:0] free_q;
  logic [PW-1:0]       ckpt_map  [NUM_CKPT][LOG_REGS];
  logic [PHY_REGS-1:0] ckpt_free [NUM_CKPT];
  logic [CW-1:0]       head_q;
  logic [CW-1:0]       tail_q;
  logic [CW:0]         count_q;

  logic                alloc;
  logic                accept;
  logic                do_alloc;
  logic                do_push;
  logic                do_pop;
  logic                do_restore;
  logic                mispredict_req;
  logic [PHY_REGS-1:0] commit_mask;
  logic [PHY_REGS-1:0] alloc_mask;
  logic [PHY_REGS-1:0] free_post;
  logic [PW:0]         free_cnt_c;
  logic [PW-1:0]       rw_phy_c;

  // Combinational lookups of the current map, ready bits and producer tags
  assign rs_phy     = map_q[rn_rs];
  assign rt_phy     = map_q[rn_rt];
  assign rw_old_phy = map_q[rn_rw];
  assign rs_tag     = tag_q[rs_phy];
  assign rt_tag     = tag_q[rt_phy];

`ifdef RENAME_WB_BYPASS_EN
  assign rs_rdy = ready_q[rs_phy] | (wb_valid & (wb_phy == rs_phy));
  assign rt_rdy = ready_q[rt_phy] | (wb_valid & (wb_phy == rt_phy));
`else
  assign rs_rdy = ready_q[rs_phy];
  assign rt_rdy = ready_q[rt_phy];
`endif

  // Population count of the free bitmap
  always_comb begin
    free_cnt_c = '0;
    for (int i = 0; i < PHY_REGS; i++) begin
      free_cnt_c = free_cnt_c + {{PW{1'b0}}, free_q[i]};
    end
  end

  // Lowest-index free register; scanning downwards lets the lowest hit win
  always_comb begin
    rw_phy_c = '0;
    for (int i = PHY_REGS - 1; i >= 0; i--) begin
      if (free_q[i]) rw_phy_c = PW'(i);
    end
  end

  assign free_count = free_cnt_c;
  assign rw_phy     = rw_phy_c;
  assign ckpt_id    = tail_q;
  assign ckpt_full  = (count_q == (CW+1)'(NUM_CKPT));

  assign alloc          = rn_uses_rw & (rn_rw != '0);
  assign mispredict_req = br_valid & br_mispredict;
  assign rn_ready       = !(alloc && (free_cnt_c == '0)) && !(rn_branch && ckpt_full) && !mispredict_req;
  assign accept         = rn_valid & rn_ready;
  assign do_alloc       = accept & alloc;
  assign do_push        = accept & rn_branch;
  assign do_restore     = mispredict_req & (count_q != '0);
  assign do_pop         = br_valid & !br_mispredict & (count_q != '0);

  // Phys 0 backs the hardwired logical 0 and is never returned to the pool
  assign commit_mask = (commit_valid && (commit_old_phy != '0)) ? (ONE_BIT << commit_old_phy) : '0;
  assign alloc_mask  = do_alloc ? (ONE_BIT << rw_phy_c) : '0;
  assign free_post   = (free_q & ~alloc_mask) | commit_mask;

  // Architectural-speculative map: restore on mispredict, else rename update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOG_REGS; i++) map_q[i] <= PW'(i);
    end else if (do_restore) begin
      for (int i = 0; i < LOG_REGS; i++) map_q[i] <= ckpt_map[head_q][i];
    end else if (do_alloc) begin
      map_q[rn_rw] <= rw_phy_c;
    end
  end

  // Free bitmap; a same-cycle commit survives a restore
  always_ff @(posedge clk or posedge rst) begin
    if (rst) free_q <= FREE_RST;
    else if (do_restore) free_q <= ckpt_free[head_q] | commit_mask;
    else free_q <= free_post;
  end

  // Ready bits: writeback sets, allocation clears (allocation wins on a tie)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= '1;
    end else begin
      if (wb_valid) ready_q[wb_phy] <= 1'b1;
      if (do_alloc) ready_q[rw_phy_c] <= 1'b0;
    end
  end

  // Producer ROB tag of each newly allocated physical register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHY_REGS; i++) tag_q[i] <= '0;
    end else if (do_alloc) begin
      tag_q[rw_phy_c] <= rn_rob_tag;
    end
  end

  // Snapshot storage: commits propagate into every slot (dead slots are
  // fully rewritten on push), and a push captures the post-rename state
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CKPT; i++) ckpt_free[i] <= ckpt_free[i] | commit_mask;
    if (do_push) begin
      ckpt_free[tail_q] <= free_post;
      for (int j = 0; j < LOG_REGS; j++) ckpt_map[tail_q][j] <= map_q[j];
      if (do_alloc) ckpt_map[tail_q][rn_rw] <= rw_phy_c;
    end
  end

  // Ring pointers: mispredict empties the ring, otherwise push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (do_restore) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + CW'(1);
      if (do_pop)  head_q <= head_q + CW'(1);
      if (do_push && !do_pop) count_q <= count_q + (CW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (CW+1)'(1);
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Testbench for rename_map_ckpt: directed vectors, scoreboard queue of
// expected output vectors, monitor that compares on accepted renames or probes.
module tb_rename_map_ckpt;

  localparam int LOG_REGS = 32;
  localparam int PHY_REGS = 64;
  localparam int TAG_W    = 4;
  localparam int NUM_CKPT = 4;
  localparam int LW = 5;
  localparam int PW = 6;
  localparam int CW = 2;
  localparam int OW = 45;
  localparam int NF = 12;
  localparam int X  = -1;

`ifdef RENAME_WB_BYPASS_EN
  localparam int WB_SAME = 1;
`else
  localparam int WB_SAME = 0;
`endif

  logic             clk;
  logic             rst;
  logic             rn_valid;
  logic             rn_uses_rw;
  logic             rn_branch;
  logic [LW-1:0]    rn_rs;
  logic [LW-1:0]    rn_rt;
  logic [LW-1:0]    rn_rw;
  logic [TAG_W-1:0] rn_rob_tag;
  logic             rn_ready;
  logic [PW-1:0]    rs_phy;
  logic [PW-1:0]    rt_phy;
  logic             rs_rdy;
  logic             rt_rdy;
  logic [TAG_W-1:0] rs_tag;
  logic [TAG_W-1:0] rt_tag;
  logic [PW-1:0]    rw_phy;
  logic [PW-1:0]    rw_old_phy;
  logic [CW-1:0]    ckpt_id;
  logic             wb_valid;
  logic [PW-1:0]    wb_phy;
  logic             commit_valid;
  logic [PW-1:0]    commit_old_phy;
  logic             br_valid;
  logic             br_mispredict;
  logic [PW:0]      free_count;
  logic             ckpt_full;

  logic             probe;
  int               total;
  int               bad;
  logic [OW-1:0]    exp_q[$];
  logic [OW-1:0]    msk_q[$];
  string            name_q[$];
  logic [OW-1:0]    mon_e;
  logic [OW-1:0]    mon_m;
  string            mon_nm;
  logic [OW-1:0]    obs;

  rename_map_ckpt #(
    .LOG_REGS(LOG_REGS), .PHY_REGS(PHY_REGS), .TAG_W(TAG_W), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk(clk), .rst(rst),
    .rn_valid(rn_valid), .rn_uses_rw(rn_uses_rw), .rn_branch(rn_branch),
    .rn_rs(rn_rs), .rn_rt(rn_rt), .rn_rw(rn_rw), .rn_rob_tag(rn_rob_tag),
    .rn_ready(rn_ready),
    .rs_phy(rs_phy), .rt_phy(rt_phy), .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
    .rs_tag(rs_tag), .rt_tag(rt_tag),
    .rw_phy(rw_phy), .rw_old_phy(rw_old_phy), .ckpt_id(ckpt_id),
    .wb_valid(wb_valid), .wb_phy(wb_phy),
    .commit_valid(commit_valid), .commit_old_phy(commit_old_phy),
    .br_valid(br_valid), .br_mispredict(br_mispredict),
    .free_count(free_count), .ckpt_full(ckpt_full)
  );

  // Clock and observed-output vector
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {rn_ready, rs_phy, rs_rdy, rs_tag, rt_phy, rt_rdy, rt_tag,
                rw_phy, rw_old_phy, ckpt_id, free_count, ckpt_full};

  // Push one expected vector; a field value of X is not compared
  task automatic expect_obs(input string nm, input int rdy, input int rsp, input int rsr,
                            input int rsg, input int rtp, input int rtr, input int rtg,
                            input int rwp, input int rwo, input int cid, input int fc,
                            input int full);
    int w[NF];
    int v[NF];
    logic [63:0] e;
    logic [63:0] m;
    logic [63:0] fm;
    w = '{1, 6, 1, 4, 6, 1, 4, 6, 6, 2, 7, 1};
    v = '{rdy, rsp, rsr, rsg, rtp, rtr, rtg, rwp, rwo, cid, fc, full};
    e = '0;
    m = '0;
    for (int i = 0; i < NF; i++) begin
      fm = (64'd1 << w[i]) - 64'd1;
      e = e << w[i];
      m = m << w[i];
      if (v[i] >= 0) begin
        e = e | (64'(v[i]) & fm);
        m = m | fm;
      end
    end
    exp_q.push_back(e[OW-1:0]);
    msk_q.push_back(m[OW-1:0]);
    name_q.push_back(nm);
  endtask

  // Driver tasks
  task automatic idle();
    rn_valid = 0; rn_uses_rw = 0; rn_branch = 0;
    rn_rs = '0; rn_rt = '0; rn_rw = '0; rn_rob_tag = '0;
    wb_valid = 0; wb_phy = '0;
    commit_valid = 0; commit_old_phy = '0;
    br_valid = 0; br_mispredict = 0;
    probe = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rn(input int valid, input int uses, input int br, input int rs,
                    input int rt, input int rw, input int tag);
    rn_valid   = (valid != 0);
    rn_uses_rw = (uses != 0);
    rn_branch  = (br != 0);
    rn_rs      = LW'(rs);
    rn_rt      = LW'(rt);
    rn_rw      = LW'(rw);
    rn_rob_tag = TAG_W'(tag);
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Monitor: compare whenever a rename is accepted or a probe is requested
  always @(negedge clk) begin
    if (probe || (rn_valid && rn_ready)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=<none>", obs);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_m  = msk_q.pop_front();
        mon_nm = name_q.pop_front();
        if (((obs ^ mon_e) & mon_m) != '0) begin
          bad++;
          $display("FAIL %s got=%h want=%h care=%h", mon_nm, obs & mon_m, mon_e, mon_m);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    rn(0, 0, 0, 7, 9, 12, 0); probe = 1;
    expect_obs("reset_state", 1, 7, 1, X, 9, 1, X, 32, 12, 0, 32, 0);
    step();

    // Back-to-back rename of rw=5 reading rs=5
    rn(1, 1, 0, 5, 0, 5, 3);
    expect_obs("rn1", 1, 5, 1, X, 0, 1, X, 32, 5, 0, 32, 0);
    step();
    rn(1, 1, 0, 5, 0, 5, 4);
    expect_obs("rn2", 1, 32, 0, 3, 0, 1, X, 33, 32, 0, 31, 0);
    step();

    // Writeback of phys 33 while rs maps to it
    rn(0, 0, 0, 5, 0, 0, 0); wb_valid = 1; wb_phy = 6'd33; probe = 1;
    expect_obs("wb_same_cycle", 1, 33, WB_SAME, 4, X, X, X, 34, X, 0, 30, 0);
    step();
    rn(0, 0, 0, 5, 0, 0, 0); probe = 1;
    expect_obs("wb_next_cycle", 1, 33, 1, 4, X, X, X, 34, X, 0, 30, 0);
    step();

    // Requests that must not allocate
    rn(1, 0, 0, 0, 0, 7, 0);
    expect_obs("no_alloc_uses0", 1, X, X, X, X, X, X, 34, 7, 0, 30, 0);
    step();
    rn(1, 1, 0, 0, 0, 0, 0);
    expect_obs("no_alloc_rw0", 1, X, X, X, X, X, X, 34, 0, 0, 30, 0);
    step();
    rn(0, 0, 0, 0, 0, 0, 0); probe = 1;
    expect_obs("no_alloc_state", 1, X, X, X, X, X, X, 34, X, 0, 30, 0);
    step();

    // Drain the free pool
    for (int i = 0; i < 30; i++) begin
      rn(1, 1, 0, 0, 0, 10, i % 16);
      expect_obs("fill", 1, X, X, X, X, X, X, 34 + i, (i == 0) ? 10 : 33 + i, 0, 30 - i, 0);
      step();
    end
    rn(1, 1, 0, 0, 0, 11, 0); probe = 1;
    expect_obs("empty_stall", 0, X, X, X, X, X, X, X, 11, 0, 0, 0);
    step();
    rn(1, 1, 0, 0, 0, 11, 0); commit_valid = 1; commit_old_phy = 6'd0; probe = 1;
    expect_obs("commit_zero_cycle", 0, X, X, X, X, X, X, X, 11, 0, 0, 0);
    step();
    rn(1, 1, 0, 0, 0, 11, 0); commit_valid = 1; commit_old_phy = 6'd5; probe = 1;
    expect_obs("commit5_cycle", 0, X, X, X, X, X, X, X, 11, 0, 0, 0);
    step();
    rn(1, 1, 0, 0, 0, 11, 0);
    expect_obs("alloc_after_commit", 1, X, X, X, X, X, X, 5, 11, 0, 1, 0);
    step();

    // Asynchronous reset mid-operation, sampled before any clock edge
    rst = 1; rn(0, 0, 0, 10, 11, 10, 0); probe = 1;
    expect_obs("async_reset", 1, 10, 1, X, 11, 1, X, 32, 10, 0, 32, 0);
    step();
    rst = 0;

    // Checkpoint, speculative rename, mispredict restore
    rn(1, 1, 1, 0, 0, 2, 1);
    expect_obs("br_ckpt", 1, X, X, X, X, X, X, 32, 2, 0, 32, 0);
    step();
    rn(1, 1, 0, 0, 0, 3, 2);
    expect_obs("after_br", 1, X, X, X, X, X, X, 33, 3, 1, 31, 0);
    step();
    rn(1, 1, 1, 0, 0, 4, 0); br_valid = 1; br_mispredict = 1; probe = 1;
    expect_obs("mispredict_block", 0, X, X, X, X, X, X, 34, 4, 1, 30, 0);
    step();
    rn(0, 0, 0, 3, 2, 4, 0); probe = 1;
    expect_obs("restore", 1, 3, 1, X, 32, 0, 1, 33, 4, 1, 31, 0);
    step();

    // Fill the ring, stall, resolve, wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rn(1, 0, 1, 0, 0, 0, 0);
      expect_obs("br_push", 1, X, X, X, X, X, X, 32, X, i, 32, 0);
      step();
    end
    rn(1, 0, 1, 0, 0, 0, 0); probe = 1;
    expect_obs("ckpt_full_stall", 0, X, X, X, X, X, X, 32, X, 0, 32, 1);
    step();
    rn(1, 1, 0, 0, 0, 6, 5);
    expect_obs("alloc_when_full", 1, X, X, X, X, X, X, 32, 6, 0, 32, 1);
    step();
    rn(1, 0, 1, 0, 0, 0, 0); br_valid = 1; probe = 1;
    expect_obs("resolve_same_cycle", 0, X, X, X, X, X, X, 33, X, 0, 31, 1);
    step();
    rn(1, 0, 1, 0, 0, 0, 0);
    expect_obs("wrap_ckpt_id", 1, X, X, X, X, X, X, 33, X, 0, 31, 0);
    step();

    // Commits after a checkpoint survive the restore
    do_reset();
    rn(1, 0, 1, 0, 0, 0, 0);
    expect_obs("ckpt5", 1, X, X, X, X, X, X, 32, X, 0, 32, 0);
    step();
    commit_valid = 1; commit_old_phy = 6'd7;
    step();
    br_valid = 1; br_mispredict = 1; commit_valid = 1; commit_old_phy = 6'd9;
    step();
    rn(1, 1, 0, 0, 0, 1, 0);
    expect_obs("commit_survives_restore", 1, X, X, X, X, X, X, 7, 1, 1, 34, 0);
    step();
    rn(1, 1, 0, 0, 0, 2, 0);
    expect_obs("commit_during_restore", 1, X, X, X, X, X, X, 9, 2, 1, 33, 0);
    step();

    // Final report
    step();
    step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
